reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer that sits directly downstream of the register file's rename logic and upstream of its commit port. It allocates one entry per issued instruction, captures results from the common data bus (CDB), retires entries in program order into the register file, and answers the register file's operand-forwarding lookups. It also raises the pipeline flush on a mispredicted branch reaching the head.

## Interface
- ROB_WIDTH, 4, log2 of entry count (16 entries); entry id = slot index
- clockIn  in  1  rising-edge clock
- resetIn  in  1  asynchronous, active-low reset
- issueValid  in  1  allocate entry at tail this cycle
- issueDest  in  5  destination register (0 = no write)
- issueIsBranch  in  1  entry is a branch/jump
- issueRobId  out  ROB_WIDTH  id the next issue receives (tail)
- robFull  out  1  no free entry
- cdbValid  in  1  result broadcast
- cdbRobId  in  ROB_WIDTH  entry being completed
- cdbValue  in  32  result value
- cdbMispredict  in  1  branch outcome differs from prediction
- cdbTarget  in  32  correct next PC for mispredicted branch
- regUpdateValid  out  1  commit write to register file
- regUpdateDest  out  5  committed destination
- regUpdateValue  out  32  committed value
- regUpdateRobId  out  ROB_WIDTH  committed entry id
- robRs1Dep, robRs2Dep  in  ROB_WIDTH  ids looked up by register file
- robRs1Ready, robRs2Ready  out  1  looked-up entry has its value
- robRs1Value, robRs2Value  out  32  looked-up entry value
- flushOut  out  1  one-cycle pipeline flush pulse
- flushPc  out  32  redirect PC, valid with flushOut

## Operation
- State: head, tail (ROB_WIDTH bits, wrap mod 2^ROB_WIDTH), count (ROB_WIDTH+1 bits); per entry busy, ready, dest, isBranch, mispredict, target, value.
- robFull = (count == 2^ROB_WIDTH); issueRobId = tail.
- Issue: issueValid && !robFull && !flushOut -> entry[tail] busy=1, ready=0, fields latched, tail+1, count+1. Issue while full or during flushOut is dropped.
- CDB: cdbValid && busy[cdbRobId] -> ready=1, value/mispredict/target latched. CDB to non-busy entry ignored.
- Commit (combinational from head): regUpdateValid = count!=0 && ready[head] && dest[head]!=0 && !flushOut; regUpdateDest/Value/RobId from head. Head advances (busy cleared, count-1) whenever count!=0 && ready[head] && !flushOut, including dest 0.
- Mispredict at head: entry commits normally (link register written), then at that edge all busy cleared, head=tail=0, count=0, flushOut<=1, flushPc<=target. Issue and CDB in that same cycle are discarded.
- Lookup: robRsNReady = ready[robRsNDep]; robRsNValue = value[robRsNDep]. ready/value persist after retirement until slot is reallocated.
- Simultaneous issue and commit: count unchanged, both pointers advance.

## Timing
- Reset (resetIn low, async): head=tail=count=0, all busy/ready=0, flushOut=0, flushPc=0; regUpdateValid=0, robRsNReady=0, robFull=0, issueRobId=0.
- CDB at edge N -> commit outputs visible in cycle N+1 if entry is head; register file writes at edge N+1.
- Issue to robFull: visible cycle after the 2^ROB_WIDTH-th accepted issue.
- flushOut high exactly one cycle after the mispredict commit edge.
- Reset deassertion mid-stream: all in-flight entries lost; no spurious commit.

## Configuration
- ROB_CDB_BYPASS_EN defined: robRsNReady also true when cdbValid && cdbRobId==robRsNDep, value taken from cdbValue (same-cycle forwarding).
- Not defined: lookups see only values stored at prior edges; one cycle extra dependency latency.

## Test plan
- Reset low mid-operation with 5 busy entries -> next cycle count 0, robFull 0, regUpdateValid 0, flushOut 0.
- Issue dest x5 (id 0), CDB id 0 value 0x1234 -> next cycle regUpdateValid=1, dest 5, value 0x1234, RobId 0; entry freed.
- Issue 16 entries -> robFull=1; 17th issue dropped; complete id 0 -> commit, robFull clears, issueRobId=0 (wrap).
- Complete ids 2,1 before 0 -> commits strictly in order 0,1,2 on consecutive cycles.
- Branch id 3 mispredict target 0x80 at head with ids 4-6 in flight -> flushOut=1, flushPc=0x80 for one cycle, count 0, ids 4-6 never commit.
- Lookup id 7 while CDB completes id 7 -> robRs1Ready=1 same cycle with ROB_CDB_BYPASS_EN, 0 without (1 next cycle).

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire, CDB capture, operand lookup, and branch-mispredict flush.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB result into the operand lookups.
module rob_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc,
  input  logic        flush,
  input  logic        retire,
  input  logic        cdb_we,
  input  logic [4:0]  dest_in,
  input  logic        br_in,
  input  logic [31:0] cdb_value,
  input  logic        cdb_mis,
  input  logic [31:0] cdb_target,
  output logic        ready,
  output logic [4:0]  dest,
  output logic        is_br,
  output logic        mis,
  output logic [31:0] target,
  output logic [31:0] value
);
  logic busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      ready  <= 1'b0;
      dest   <= '0;
      is_br  <= 1'b0;
      mis    <= 1'b0;
      target <= '0;
      value  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (alloc) begin
      busy  <= 1'b1;
      ready <= 1'b0;
      dest  <= dest_in;
      is_br <= br_in;
      mis   <= 1'b0;
    end else begin
      if (retire) busy <= 1'b0;
      // ready/value stay visible after retire until the slot is reused
      if (cdb_we && busy) begin
        ready  <= 1'b1;
        value  <= cdb_value;
        mis    <= cdb_mis;
        target <= cdb_target;
      end
    end
  end
endmodule

module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 issueValid,
  input  logic [4:0]           issueDest,
  input  logic                 issueIsBranch,
  output logic [ROB_WIDTH-1:0] issueRobId,
  output logic                 robFull,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbMispredict,
  input  logic [31:0]          cdbTarget,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic [ROB_WIDTH-1:0] robRs1Dep,
  input  logic [ROB_WIDTH-1:0] robRs2Dep,
  output logic                 robRs1Ready,
  output logic                 robRs2Ready,
  output logic [31:0]          robRs1Value,
  output logic [31:0]          robRs2Value,
  output logic                 flushOut,
  output logic [31:0]          flushPc
);
  localparam int N = 1 << ROB_WIDTH;

  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count, count_nxt;

  logic [N-1:0]         ready_v, br_v, mis_v;
  logic [N-1:0][4:0]    dest_v;
  logic [N-1:0][31:0]   value_v, target_v;

  logic commit_go, flush_now, issue_go, cdb_go;

  assign robFull    = (count == (ROB_WIDTH+1)'(N));
  assign issueRobId = tail;

  assign commit_go = (count != '0) && ready_v[head] && !flushOut;
  // a mispredicted branch still retires (link write) before the flush lands
  assign flush_now = commit_go && br_v[head] && mis_v[head];
  assign issue_go  = issueValid && !robFull && !flushOut && !flush_now;
  assign cdb_go    = cdbValid && !flush_now;

  assign regUpdateValid = commit_go && (dest_v[head] != 5'd0);
  assign regUpdateDest  = dest_v[head];
  assign regUpdateValue = value_v[head];
  assign regUpdateRobId = head;

  always_comb begin
    count_nxt = count;
    unique case ({issue_go, commit_go})
      2'b10:   count_nxt = count + (ROB_WIDTH+1)'(1);
      2'b01:   count_nxt = count - (ROB_WIDTH+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      flushOut <= 1'b0;
      flushPc  <= '0;
    end else if (flush_now) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      flushOut <= 1'b1;
      flushPc  <= target_v[head];
    end else begin
      flushOut <= 1'b0;
      count    <= count_nxt;
      if (commit_go) head <= head + ROB_WIDTH'(1);
      if (issue_go)  tail <= tail + ROB_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ent
    rob_entry u_ent (
      .clk        (clockIn),
      .rst_n      (resetIn),
      .alloc      (issue_go && (tail == ROB_WIDTH'(i))),
      .flush      (flush_now),
      .retire     (commit_go && (head == ROB_WIDTH'(i))),
      .cdb_we     (cdb_go && (cdbRobId == ROB_WIDTH'(i))),
      .dest_in    (issueDest),
      .br_in      (issueIsBranch),
      .cdb_value  (cdbValue),
      .cdb_mis    (cdbMispredict),
      .cdb_target (cdbTarget),
      .ready      (ready_v[i]),
      .dest       (dest_v[i]),
      .is_br      (br_v[i]),
      .mis        (mis_v[i]),
      .target     (target_v[i]),
      .value      (value_v[i])
    );
  end

`ifdef ROB_CDB_BYPASS_EN
  always_comb begin
    robRs1Ready = ready_v[robRs1Dep];
    robRs1Value = value_v[robRs1Dep];
    robRs2Ready = ready_v[robRs2Dep];
    robRs2Value = value_v[robRs2Dep];
    if (cdbValid && cdbRobId == robRs1Dep) begin
      robRs1Ready = 1'b1;
      robRs1Value = cdbValue;
    end
    if (cdbValid && cdbRobId == robRs2Dep) begin
      robRs2Ready = 1'b1;
      robRs2Value = cdbValue;
    end
  end
`else
  assign robRs1Ready = ready_v[robRs1Dep];
  assign robRs1Value = value_v[robRs1Dep];
  assign robRs2Ready = ready_v[robRs2Dep];
  assign robRs2Value = value_v[robRs2Dep];
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized + directed bench for reorder_buffer against an in-order queue model.
module tb_reorder_buffer;
  logic        clockIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        issueValid = 1'b0, issueIsBranch = 1'b0;
  logic [4:0]  issueDest = '0;
  logic [3:0]  issueRobId;
  logic        robFull;
  logic        cdbValid = 1'b0, cdbMispredict = 1'b0;
  logic [3:0]  cdbRobId = '0;
  logic [31:0] cdbValue = '0, cdbTarget = '0;
  logic        regUpdateValid;
  logic [4:0]  regUpdateDest;
  logic [31:0] regUpdateValue;
  logic [3:0]  regUpdateRobId;
  logic [3:0]  robRs1Dep = '0, robRs2Dep = '0;
  logic        robRs1Ready, robRs2Ready;
  logic [31:0] robRs1Value, robRs2Value;
  logic        flushOut;
  logic [31:0] flushPc;

  reorder_buffer #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .issueValid(issueValid), .issueDest(issueDest), .issueIsBranch(issueIsBranch),
    .issueRobId(issueRobId), .robFull(robFull),
    .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue),
    .cdbMispredict(cdbMispredict), .cdbTarget(cdbTarget),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
    .robRs1Dep(robRs1Dep), .robRs2Dep(robRs2Dep),
    .robRs1Ready(robRs1Ready), .robRs2Ready(robRs2Ready),
    .robRs1Value(robRs1Value), .robRs2Value(robRs2Value),
    .flushOut(flushOut), .flushPc(flushPc)
  );

  always #5 clockIn = ~clockIn;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int errors = 0, checks = 0;

  // model: program-order queue of live ids plus per-slot result fields
  int          q[$];
  bit          mbusy[16], mrdy[16], mbr[16], mmis[16];
  logic [4:0]  mdst[16];
  logic [31:0] mval[16], mtgt[16];
  int          mtail;
  bit          mflush;
  logic [31:0] mfpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) begin
      mbusy[i] = 0; mrdy[i] = 0; mbr[i] = 0; mmis[i] = 0;
      mdst[i] = '0; mval[i] = '0; mtgt[i] = '0;
    end
    mtail = 0; mflush = 0; mfpc = '0;
  endtask

  task automatic lookup_chk(input string tag, input logic [3:0] d,
                            input logic rdy, input logic [31:0] val);
    bit          er;
    logic [31:0] ev;
    er = mrdy[d];
    ev = mval[d];
    if (BYP && cdbValid && cdbRobId == d) begin
      er = 1'b1;
      ev = cdbValue;
    end
    chk({tag, "Ready"}, 32'(rdy), 32'(er));
    chk({tag, "Value"}, val, ev);
  endtask

  task automatic check_now();
    bit cg, rv;
    cg = q.size() > 0 && mrdy[q[0]] && !mflush;
    rv = cg && mdst[q[0]] != 5'd0;
    chk("robFull", 32'(robFull), 32'(q.size() == 16));
    chk("issueRobId", 32'(issueRobId), 32'(mtail));
    chk("flushOut", 32'(flushOut), 32'(mflush));
    if (mflush) chk("flushPc", flushPc, mfpc);
    chk("regUpdateValid", 32'(regUpdateValid), 32'(rv));
    if (rv) begin
      chk("regUpdateDest", 32'(regUpdateDest), 32'(mdst[q[0]]));
      chk("regUpdateValue", regUpdateValue, mval[q[0]]);
      chk("regUpdateRobId", 32'(regUpdateRobId), 32'(q[0]));
    end
    lookup_chk("rs1", robRs1Dep, robRs1Ready, robRs1Value);
    lookup_chk("rs2", robRs2Dep, robRs2Ready, robRs2Value);
  endtask

  task automatic model_step();
    bit cg, full, fl;
    int h;
    cg   = q.size() > 0 && mrdy[q[0]] && !mflush;
    h    = cg ? q[0] : 0;
    full = q.size() == 16;
    fl   = mflush;
    if (cg && mbr[h] && mmis[h]) begin
      for (int i = 0; i < 16; i++) mbusy[i] = 0;
      q.delete();
      mtail = 0; mflush = 1; mfpc = mtgt[h];
    end else begin
      mflush = 0;
      if (cdbValid && mbusy[cdbRobId]) begin
        mrdy[cdbRobId] = 1; mval[cdbRobId] = cdbValue;
        mmis[cdbRobId] = cdbMispredict; mtgt[cdbRobId] = cdbTarget;
      end
      if (cg) begin
        mbusy[h] = 0;
        void'(q.pop_front());
      end
      if (issueValid && !full && !fl) begin
        mbusy[mtail] = 1; mrdy[mtail] = 0; mmis[mtail] = 0;
        mdst[mtail] = issueDest; mbr[mtail] = issueIsBranch;
        q.push_back(mtail);
        mtail = (mtail + 1) % 16;
      end
    end
  endtask

  task automatic step(input bit iv, input logic [4:0] dst, input bit br,
                      input bit cv, input logic [3:0] cid, input logic [31:0] cval,
                      input bit cmis, input logic [31:0] ctgt,
                      input logic [3:0] d1, input logic [3:0] d2);
    @(negedge clockIn);
    issueValid = iv; issueDest = dst; issueIsBranch = br;
    cdbValid = cv; cdbRobId = cid; cdbValue = cval;
    cdbMispredict = cmis; cdbTarget = ctgt;
    robRs1Dep = d1; robRs2Dep = d2;
    #1;
    check_now();
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd0, 4'd1);
  endtask

  task automatic issue(input logic [4:0] dst, input bit br);
    step(1, dst, br, 0, 4'd0, 32'd0, 0, 32'd0, 4'd0, 4'd1);
  endtask

  task automatic cdb(input logic [3:0] id, input logic [31:0] val, input bit mis,
                     input logic [31:0] tgt);
    step(0, 5'd0, 0, 1, id, val, mis, tgt, id, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clockIn);
    issueValid = 0; cdbValid = 0; cdbMispredict = 0;
    resetIn = 0;
    #1;
    model_reset();
    check_now();
    @(negedge clockIn);
    resetIn = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // reset drops five in-flight entries
    for (int i = 0; i < 5; i++) issue(5'(i + 1), 0);
    do_reset();
    idle(1);

    // single issue -> complete -> commit
    issue(5'd5, 0);
    cdb(4'd0, 32'h1234, 0, 32'd0);
    idle(2);

    // fill to 16, 17th dropped, completing id 0 frees a slot and tail wraps to 0
    do_reset();
    for (int i = 0; i < 17; i++) issue(5'(i % 31 + 1), 0);
    cdb(4'd0, 32'hAAAA_0000, 0, 32'd0);
    idle(2);

    // out-of-order completion retires in order
    do_reset();
    for (int i = 0; i < 3; i++) issue(5'(i + 10), 0);
    cdb(4'd2, 32'h22, 0, 32'd0);
    cdb(4'd1, 32'h11, 0, 32'd0);
    cdb(4'd0, 32'h00, 0, 32'd0);
    idle(4);

    // mispredicted branch at id 3 squashes ids 4-6
    do_reset();
    for (int i = 0; i < 3; i++) issue(5'(i + 1), 0);
    issue(5'd1, 1);
    for (int i = 0; i < 3; i++) issue(5'(i + 7), 0);
    for (int i = 4; i < 7; i++) cdb(4'(i), 32'(i * 3), 0, 32'd0);
    for (int i = 0; i < 3; i++) cdb(4'(i), 32'(i + 100), 0, 32'd0);
    cdb(4'd3, 32'h44, 1, 32'h80);
    idle(4);

    // lookup of id 7 in the same cycle it completes
    do_reset();
    for (int i = 0; i < 8; i++) issue(5'(i + 1), 0);
    @(negedge clockIn);
    issueValid = 0; cdbValid = 1; cdbRobId = 4'd7; cdbValue = 32'h7777;
    cdbMispredict = 0; robRs1Dep = 4'd7; robRs2Dep = 4'd6;
    #1;
    chk("bypassRs1Ready", 32'(robRs1Ready), 32'(BYP));
    check_now();
    model_step();
    step(0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 32'd0, 4'd7, 4'd7);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          iv, br, cv, cm;
      logic [3:0]  cid;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      iv  = ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 4) == 0);
      cv  = ($urandom_range(0, 1) == 1);
      if (q.size() > 0 && $urandom_range(0, 7) != 0)
        cid = 4'(q[$urandom_range(0, q.size() - 1)]);
      else
        cid = 4'($urandom_range(0, 15));
      cm = mbr[cid] && ($urandom_range(0, 5) == 0);
      step(iv, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), br,
           cv, cid, $urandom, cm, $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
